msdap_out_serializer: RTL and testbench

MSDAP_OUT_SERIALIZER -- requirements
Module: msdap_out_serializer

---
 rtl/msdap_pkg.sv | 12 +
 rtl/msdap_shift_lane.sv | 28 ++
 rtl/msdap_out_serializer.sv | 122 ++++++++++++
 tb/tb_msdap_out_serializer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msdap_pkg.sv
// Shared MSDAP constants: default serial word width and serializer FSM encoding.
package msdap_pkg;

  localparam int MSDAP_WIDTH = 40;
  localparam int MSDAP_CNT_W = 6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } msdap_state_t;

endpackage

// File: rtl/msdap_shift_lane.sv
// One serial output lane: WIDTH-bit parallel-load register shifting MSB first.
module msdap_shift_lane #(
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout
);

  logic [WIDTH-1:0] sreg;

  // After k shifts the MSB holds original bit WIDTH-1-k, which equals the FSM bit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign dout = sreg[WIDTH-1];

endmodule

// File: rtl/msdap_out_serializer.sv
// Stereo output serializer: lockstep L/R shifters, one pending word, gapless reload at bit 0.
module msdap_out_serializer
  import msdap_pkg::*;
#(
  parameter int WIDTH = MSDAP_WIDTH
) (
  input  logic             Sclk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] DataL,
  input  logic [WIDTH-1:0] DataR,
  input  logic             DataValid,
  output logic             DataReady,
  output logic             OutReady,
  output logic             OutputL,
  output logic             OutputR,
  output msdap_state_t     fsm_state
);

  // Handshake: a word moves on a rising Sclk where DataValid and DataReady are both 1;
  // the producer holds DataL/DataR stable until then, and DataReady never depends on DataValid.

  msdap_state_t           state;
  logic [MSDAP_CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0]       pend_l;
  logic [WIDTH-1:0]       pend_r;
  logic                   pend_valid;

  logic                   transfer;
  logic                   lane_load;
  logic                   lane_shift;
  logic [WIDTH-1:0]       load_l;
  logic [WIDTH-1:0]       load_r;
  logic                   lane_l_bit;
  logic                   lane_r_bit;

  assign transfer = DataValid & DataReady;

  // Shifter source: pending word wins at bit 0; otherwise a fresh transfer loads directly.
  always_comb begin
    lane_load  = 1'b0;
    lane_shift = 1'b0;
    load_l     = DataL;
    load_r     = DataR;
    if (state == ST_IDLE) begin
      lane_load = transfer;
    end else if (bit_cnt == '0) begin
      if (pend_valid) begin
        lane_load = 1'b1;
        load_l    = pend_l;
        load_r    = pend_r;
      end else begin
        lane_load = transfer;
      end
    end else begin
      lane_shift = 1'b1;
    end
  end

  always_ff @(posedge Sclk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      pend_l     <= '0;
      pend_r     <= '0;
      pend_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (transfer) begin
            state   <= ST_SHIFT;
            bit_cnt <= MSDAP_CNT_W'(WIDTH - 1);
          end
        end
        ST_SHIFT: begin
          if (bit_cnt == '0) begin
            if (pend_valid) begin
              pend_valid <= 1'b0;
              bit_cnt    <= MSDAP_CNT_W'(WIDTH - 1);
            end else if (transfer) begin
              bit_cnt <= MSDAP_CNT_W'(WIDTH - 1);
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
            if (transfer) begin
              pend_l     <= DataL;
              pend_r     <= DataR;
              pend_valid <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  msdap_shift_lane #(.WIDTH(WIDTH)) u_lane_l (
    .clk   (Sclk),
    .rst   (Reset),
    .load  (lane_load),
    .shift (lane_shift),
    .din   (load_l),
    .dout  (lane_l_bit)
  );

  msdap_shift_lane #(.WIDTH(WIDTH)) u_lane_r (
    .clk   (Sclk),
    .rst   (Reset),
    .load  (lane_load),
    .shift (lane_shift),
    .din   (load_r),
    .dout  (lane_r_bit)
  );

  assign DataReady = ~pend_valid;
  assign OutReady  = (state == ST_SHIFT);
  assign OutputL   = OutReady & lane_l_bit;
  assign OutputR   = OutReady & lane_r_bit;
  assign fsm_state = state;

endmodule

// File: tb/tb_msdap_out_serializer.sv
// Bench for msdap_out_serializer: bit-stream queue model checked every cycle, plus directed literal checks.
module tb_msdap_out_serializer;
  import msdap_pkg::*;

  localparam int W = 40;

  logic         Sclk = 1'b0;
  logic         Reset = 1'b1;
  logic [W-1:0] DataL = '0;
  logic [W-1:0] DataR = '0;
  logic         DataValid = 1'b0;
  logic         DataReady;
  logic         OutReady;
  logic         OutputL;
  logic         OutputR;
  msdap_state_t fsm_state;

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;
  int sent_cnt = 0;

  // Model: every accepted word appends its W {L,R} bit pairs; the consumer pops one per SHIFT cycle.
  logic [1:0] exp_q[$];
  int acc_cnt = 0;

  // Monitor of what the DUT actually emitted.
  logic [1:0] cap_q[$];
  int runs_q[$];
  int run_len = 0;
  int ready_low = 0;

  logic [W-1:0] sent_l_q[$];
  logic [W-1:0] sent_r_q[$];

  always #5 Sclk = ~Sclk;

  msdap_out_serializer #(.WIDTH(W)) dut (
    .Sclk      (Sclk),
    .Reset     (Reset),
    .DataL     (DataL),
    .DataR     (DataR),
    .DataValid (DataValid),
    .DataReady (DataReady),
    .OutReady  (OutReady),
    .OutputL   (OutputL),
    .OutputR   (OutputR),
    .fsm_state (fsm_state)
  );

  // A word is pending exactly when more than one word's worth of bits is still queued.
  always @(posedge Sclk) begin : model
    logic acc;
    acc = DataValid && (exp_q.size() <= W);
    if (Reset) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) begin
        acc_cnt++;
        for (int i = W - 1; i >= 0; i--) exp_q.push_back({DataL[i], DataR[i]});
      end
    end
  end

  always @(negedge Sclk) begin : monitor
    if (OutReady === 1'b1) begin
      run_len++;
      cap_q.push_back({OutputL, OutputR});
    end else if (run_len > 0) begin
      runs_q.push_back(run_len);
      run_len = 0;
    end
    if (DataReady === 1'b0) ready_low++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    logic busy;
    busy = (exp_q.size() > 0);
    check("data_ready", 64'(DataReady), 64'(exp_q.size() <= W));
    check("out_ready", 64'(OutReady), 64'(busy));
    check("output_l", 64'(OutputL), busy ? 64'(exp_q[0][1]) : 64'(0));
    check("output_r", 64'(OutputR), busy ? 64'(exp_q[0][0]) : 64'(0));
    check("fsm_state", 64'(fsm_state == ST_SHIFT), 64'(busy));
  endtask

  function automatic logic [W-1:0] cap_word(input int base, input int ch);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++)
      if (base + i < cap_q.size()) w[W-1-i] = cap_q[base+i][ch];
    return w;
  endfunction

  function automatic int run_at(input int idx);
    return (idx < runs_q.size()) ? runs_q[idx] : -1;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_word(input logic [W-1:0] l, input logic [W-1:0] r);
    int n;
    n = 0;
    DataL = l;
    DataR = r;
    DataValid = 1'b1;
    @(negedge Sclk);
    while (DataReady !== 1'b1 && n < 200) begin
      @(negedge Sclk);
      n++;
    end
    check("handshake_timeout", 64'(DataReady), 64'(1));
    @(posedge Sclk);
    #1;
    DataValid = 1'b0;
    DataL = '0;
    DataR = '0;
    sent_cnt++;
    sent_l_q.push_back(l);
    sent_r_q.push_back(r);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge Sclk);
    while ((OutReady !== 1'b0 || DataReady !== 1'b1) && n < 400) begin
      @(negedge Sclk);
      n++;
    end
    check("idle_timeout", 64'(OutReady), 64'(0));
    @(posedge Sclk);
    #1;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got running, want done");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int b_cap, b_run, b_low, b_sent, gap;
    logic [63:0] t;
    logic [W-1:0] rl, rr;

    fork
      forever begin
        @(negedge Sclk);
        if (chk_en) cmp_cycle();
      end
    join_none

    // Reset state
    repeat (3) @(posedge Sclk);
    #1;
    chk_en = 1'b1;
    @(negedge Sclk);
    check("rst_data_ready", 64'(DataReady), 64'(1));
    check("rst_out_ready", 64'(OutReady), 64'(0));
    check("rst_output_l", 64'(OutputL), 64'(0));
    check("rst_output_r", 64'(OutputR), 64'(0));
    check("rst_fsm_idle", 64'(fsm_state), 64'(ST_IDLE));
    @(posedge Sclk);
    #1;
    Reset = 1'b0;
    repeat (2) @(posedge Sclk);
    #1;

    // Single word
    b_cap = cap_q.size();
    b_run = runs_q.size();
    send_word(40'h80_0000_0001, 40'h00_0000_0000);
    wait_idle();
    check("single_runs", 64'(runs_q.size() - b_run), 64'(1));
    check("single_len", 64'(run_at(b_run)), 64'(40));
    check("single_first_l", 64'(cap_q[b_cap][1]), 64'(1));
    check("single_last_l", 64'(cap_q[b_cap+39][1]), 64'(1));
    check("single_word_l", 64'(cap_word(b_cap, 1)), 64'h80_0000_0001);
    check("single_word_r", 64'(cap_word(b_cap, 0)), 64'h0);

    // Back-to-back pair
    b_cap = cap_q.size();
    b_run = runs_q.size();
    b_low = ready_low;
    send_word(40'hAA_AAAA_AAAA, 40'h55_5555_5555);
    send_word(40'h55_5555_5555, 40'hAA_AAAA_AAAA);
    wait_idle();
    check("b2b_len", 64'(run_at(b_run)), 64'(80));
    check("b2b_ready_low", 64'(ready_low - b_low), 64'(39));
    check("b2b_w0_l", 64'(cap_word(b_cap, 1)), 64'hAA_AAAA_AAAA);
    check("b2b_w1_l", 64'(cap_word(b_cap + 40, 1)), 64'h55_5555_5555);
    check("b2b_w1_r", 64'(cap_word(b_cap + 40, 0)), 64'hAA_AAAA_AAAA);

    // Third word stalls behind a full pending slot
    b_cap = cap_q.size();
    b_run = runs_q.size();
    send_word(40'h12_3456_789A, 40'hC3_C3C3_C3C3);
    send_word(40'hFE_DCBA_9876, 40'h01_0203_0405);
    send_word(40'h0F_0F0F_0F0F, 40'hF0_F0F0_F0F0);
    wait_idle();
    check("three_len", 64'(run_at(b_run)), 64'(120));
    check("three_w0_l", 64'(cap_word(b_cap, 1)), 64'h12_3456_789A);
    check("three_w1_l", 64'(cap_word(b_cap + 40, 1)), 64'hFE_DCBA_9876);
    check("three_w2_l", 64'(cap_word(b_cap + 80, 1)), 64'h0F_0F0F_0F0F);
    check("three_w2_r", 64'(cap_word(b_cap + 80, 0)), 64'hF0_F0F0_F0F0);

    // Transfer lands exactly on the bit-0 edge with no pending word
    b_cap = cap_q.size();
    b_run = runs_q.size();
    send_word(40'h96_0000_0069, 40'h3C_FFFF_FF3C);
    repeat (39) @(posedge Sclk);
    #1;
    send_word(40'h81_2345_6781, 40'h7E_0000_007E);
    wait_idle();
    check("bit0_len", 64'(run_at(b_run)), 64'(80));
    check("bit0_w1_l", 64'(cap_word(b_cap + 40, 1)), 64'h81_2345_6781);
    check("bit0_w1_r", 64'(cap_word(b_cap + 40, 0)), 64'h7E_0000_007E);

    // Reset at bit 20 with a pending word
    b_run = runs_q.size();
    send_word(40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF);
    send_word(40'hEE_EEEE_EEEE, 40'hDD_DDDD_DDDD);
    repeat (18) @(posedge Sclk);
    #1;
    Reset = 1'b1;
    @(posedge Sclk);
    #1;
    Reset = 1'b0;
    @(negedge Sclk);
    check("rstmid_out_ready", 64'(OutReady), 64'(0));
    check("rstmid_data_ready", 64'(DataReady), 64'(1));
    @(posedge Sclk);
    #1;
    wait_idle();
    check("rstmid_len", 64'(run_at(b_run)), 64'(20));
    b_cap = cap_q.size();
    send_word(40'h5A_0123_45A5, 40'hA5_FEDC_BA5A);
    wait_idle();
    check("rstmid_after_len", 64'(run_at(b_run + 1)), 64'(40));
    check("rstmid_after_l", 64'(cap_word(b_cap, 1)), 64'h5A_0123_45A5);
    check("rstmid_after_r", 64'(cap_word(b_cap, 0)), 64'hA5_FEDC_BA5A);

    // Reset wins over a simultaneous transfer
    b_cap = cap_q.size();
    DataL = 40'h11_1111_1111;
    DataR = 40'h22_2222_2222;
    DataValid = 1'b1;
    Reset = 1'b1;
    @(posedge Sclk);
    #1;
    DataValid = 1'b0;
    Reset = 1'b0;
    repeat (3) @(posedge Sclk);
    #1;
    check("rst_xfer_no_bits", 64'(cap_q.size() - b_cap), 64'(0));

    // 1000 words with random values and random gaps
    b_cap = cap_q.size();
    b_sent = sent_l_q.size();
    for (int k = 0; k < 1000; k++) begin
      gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 60)) : int'($urandom_range(0, 1)) * int'($urandom_range(0, 3));
      if (gap > 0) begin
        repeat (gap) @(posedge Sclk);
        #1;
      end
      t = {$urandom(), $urandom()};
      rl = t[W-1:0];
      t = {$urandom(), $urandom()};
      rr = t[W-1:0];
      send_word(rl, rr);
    end
    wait_idle();
    check("rand_words_emitted", 64'(cap_q.size() - b_cap), 64'(1000 * W));
    for (int k = 0; k < 1000; k++) begin
      check("rand_word_l", 64'(cap_word(b_cap + k * W, 1)), 64'(sent_l_q[b_sent + k]));
      check("rand_word_r", 64'(cap_word(b_cap + k * W, 0)), 64'(sent_r_q[b_sent + k]));
    end
    check("accepted_count", 64'(acc_cnt), 64'(sent_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
